// File: rtl/clock_ratio_meter.sv
// ---------------------------------------------------------------------------
// clock_ratio_meter
//
// Purpose:
//   Measures a slow clock (for example a clock_divider output) in the fast
//   clock_in domain. sig_in is synchronised, the number of clock_in cycles
//   between its rising edges is reported as period_out, and each period is
//   checked against EXPECTED_RATIO +/- TOLERANCE. After LOCK_COUNT
//   consecutive in-range periods, locked is raised. If no rising edge
//   arrives for TIMEOUT_CYCLES cycles, timeout is raised. The keypad design
//   uses this block to confirm the scan clock before the scanner starts.
//
// Ports:
//   clock_in    in   1   fast reference clock
//   reset       in   1   asynchronous, active-high
//   sig_in      in   1   slow clock under test, asynchronous to clock_in
//   period_out  out  20  last measured period, in clock_in cycles
//   high_out    out  20  high time of the last measured period
//   meas_valid  out  1   1-cycle pulse: period_out, high_out, in_range updated
//   in_range    out  1   last period within EXPECTED_RATIO +/- TOLERANCE
//   locked      out  1   LOCK_COUNT consecutive in-range periods seen
//   timeout     out  1   no rising edge for TIMEOUT_CYCLES
//
// Configuration:
//   CLOCK_RATIO_METER_DUTY_EN  when defined, the high time of each period is
//   measured and reported on high_out. Otherwise high_out is tied to zero.
// ---------------------------------------------------------------------------
module clock_ratio_meter #(
    parameter int unsigned EXPECTED_RATIO = 50000,
    parameter int unsigned TOLERANCE      = 16,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        sig_in,
    output logic [19:0] period_out,
    output logic [19:0] high_out,
    output logic        meas_valid,
    output logic        in_range,
    output logic        locked,
    output logic        timeout
);

    localparam logic [19:0]        TIMEOUT_VAL = 20'(TIMEOUT_CYCLES);
    localparam logic [3:0]         LOCK_VAL    = 4'(LOCK_COUNT);
    localparam logic signed [20:0] EXP_S       = 21'(EXPECTED_RATIO);
    localparam logic signed [20:0] TOL_S       = 21'(TOLERANCE);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        TIMEOUT
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] period_q, period_d;
    logic        meas_valid_q, meas_valid_d;
    logic        in_range_q, in_range_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  ok_cnt_q, ok_cnt_d;

    logic               rise, fall;
    logic signed [20:0] diff, abs_diff;
    logic               cnt_in_range;

    // Every edge sees the same synchroniser latency, so rise-to-rise spacing
    // in the s2/s3 domain equals the true period.
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // One extra bit keeps the signed difference free of overflow.
    assign diff         = $signed({1'b0, cnt_q}) - EXP_S;
    assign abs_diff     = diff[20] ? -diff : diff;
    assign cnt_in_range = (abs_diff <= TOL_S);

    // State and datapath registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_FIRST;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            ok_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            in_range_q   <= in_range_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            ok_cnt_q     <= ok_cnt_d;
        end
    end

    // Next-state logic. When a rise and the timeout limit coincide, the rise
    // wins because the timeout branch requires no rise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FIRST: if (rise) state_d = MEASURE;
            MEASURE:    if (!rise && cnt_q == TIMEOUT_VAL) state_d = TIMEOUT;
            TIMEOUT:    if (rise) state_d = MEASURE;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    // Datapath and output updates. This covers the synchroniser, the cycle
    // counter, measurement capture, the lock counter and the timeout flag.
    always_comb begin
        s1_d         = sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        in_range_d   = in_range_q;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        ok_cnt_d     = ok_cnt_q;

        // The counter only runs while measuring. It holds at the timeout
        // limit and never wraps.
        if (rise) begin
            cnt_d = 20'd1;
        end else if (state_q == MEASURE && cnt_q != TIMEOUT_VAL && cnt_q != '1) begin
            cnt_d = cnt_q + 20'd1;
        end

        if (state_q == MEASURE && rise) begin
            period_d     = cnt_q;
            meas_valid_d = 1'b1;
            in_range_d   = cnt_in_range;
            if (cnt_in_range) begin
                ok_cnt_d = (ok_cnt_q >= LOCK_VAL) ? LOCK_VAL : ok_cnt_q + 4'd1;
                if (ok_cnt_d == LOCK_VAL) locked_d = 1'b1;
            end else begin
                ok_cnt_d = '0;
                locked_d = 1'b0;
            end
        end else if (state_q == MEASURE && cnt_q == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            ok_cnt_d  = '0;
        end else if (state_q == TIMEOUT && rise) begin
            timeout_d = 1'b0;
        end
    end

    assign period_out = period_q;
    assign meas_valid = meas_valid_q;
    assign in_range   = in_range_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

`ifdef CLOCK_RATIO_METER_DUTY_EN
    logic [19:0] hi_cnt_q, hi_cnt_d;
    logic [19:0] hi_lat_q, hi_lat_d;
    logic        fall_seen_q, fall_seen_d;
    logic [19:0] high_q, high_d;

    // High-time registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            hi_cnt_q    <= '0;
            hi_lat_q    <= '0;
            fall_seen_q <= 1'b0;
            high_q      <= '0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            hi_lat_q    <= hi_lat_d;
            fall_seen_q <= fall_seen_d;
            high_q      <= high_d;
        end
    end

    // The high time is latched at the fall and published at the next rise.
    // If no fall occurs within a period, the whole period is reported as
    // high time.
    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        hi_lat_d    = hi_lat_q;
        fall_seen_d = fall_seen_q;
        high_d      = high_q;

        if (rise) begin
            hi_cnt_d = 20'd1;
        end else if (s2_q && hi_cnt_q != '1) begin
            hi_cnt_d = hi_cnt_q + 20'd1;
        end

        if (fall) begin
            hi_lat_d    = hi_cnt_q;
            fall_seen_d = 1'b1;
        end else if (rise) begin
            fall_seen_d = 1'b0;
        end

        if (state_q == MEASURE && rise) begin
            high_d = fall_seen_q ? hi_lat_q : cnt_q;
        end
    end

    assign high_out = high_q;
`else
    assign high_out = 20'd0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Testbench for clock_ratio_meter. sig_in is driven on the falling edge of
// clock_in, so every rising edge samples a stable value. A reference model
// works on the sampled sig_in stream, using edge positions and plain
// arithmetic. Its results are delayed by the two-cycle synchroniser and
// capture latency, then compared with the DUT on every cycle.
module tb_clock_ratio_meter;

   localparam int EXP   = 10;
   localparam int TOL   = 1;
   localparam int LOCKN = 4;
   localparam int TMO   = 25;

   logic        clock_in = 1'b0;
   logic        reset;
   logic        sig_in;
   logic [19:0] period_out;
   logic [19:0] high_out;
   logic        meas_valid;
   logic        in_range;
   logic        locked;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   clock_ratio_meter #(
      .EXPECTED_RATIO(EXP),
      .TOLERANCE     (TOL),
      .LOCK_COUNT    (LOCKN),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .sig_in    (sig_in),
      .period_out(period_out),
      .high_out  (high_out),
      .meas_valid(meas_valid),
      .in_range  (in_range),
      .locked    (locked),
      .timeout   (timeout)
   );

   // Free-running reference clock.
   always #5 clock_in = ~clock_in;

   typedef struct packed {
      logic [19:0] period;
      logic [19:0] high;
      logic        mv;
      logic        inr;
      logic        lck;
      logic        to;
   } obs_t;

   typedef enum {M_WAIT, M_MEAS, M_TO} mstate_t;

   mstate_t mState;
   obs_t    cur, pipeA, pipeB;
   int      cyc, lastRise, hiLatM, okM;
   bit      fallSeenM;
   logic    prevV;

   // Counts one comparison and reports it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference model step for one sampled value of sig_in.
   task automatic modelStep(input logic v, input logic rst);
      bit rise, fall;
      int p;
      if (rst) begin
         mState    = M_WAIT;
         cur       = '0;
         pipeA     = '0;
         pipeB     = '0;
         prevV     = 1'b0;
         okM       = 0;
         fallSeenM = 0;
         cyc       = 0;
         lastRise  = 0;
         hiLatM    = 0;
         return;
      end
      cyc++;
      rise   = v && !prevV;
      fall   = !v && prevV;
      cur.mv = 1'b0;
      if (fall) begin
         hiLatM    = cyc - lastRise;
         fallSeenM = 1;
      end
      case (mState)
         M_WAIT: if (rise) begin
            mState = M_MEAS; lastRise = cyc; fallSeenM = 0;
         end
         M_MEAS: if (rise) begin
            p          = cyc - lastRise;
            cur.period = 20'(p);
`ifdef CLOCK_RATIO_METER_DUTY_EN
            cur.high   = fallSeenM ? 20'(hiLatM) : 20'(p);
`else
            cur.high   = 20'd0;
`endif
            cur.mv     = 1'b1;
            cur.inr    = (p - EXP <= TOL) && (EXP - p <= TOL);
            if (cur.inr) begin
               okM = (okM + 1 > LOCKN) ? LOCKN : okM + 1;
               if (okM == LOCKN) cur.lck = 1'b1;
            end else begin
               okM     = 0;
               cur.lck = 1'b0;
            end
            lastRise  = cyc;
            fallSeenM = 0;
         end else if (cyc - lastRise == TMO) begin
            mState  = M_TO;
            cur.to  = 1'b1;
            cur.lck = 1'b0;
            okM     = 0;
         end
         M_TO: if (rise) begin
            cur.to = 1'b0; mState = M_MEAS; lastRise = cyc; fallSeenM = 0;
         end
         default: mState = M_WAIT;
      endcase
      prevV = v;
   endtask

   // Drives one clock_in cycle, advances the model and compares all outputs.
   task automatic stepCycle(input logic v);
      sig_in = v;
      @(posedge clock_in);
      modelStep(v, reset);
      #1;
      checkOutput("meas_valid", 32'(meas_valid), 32'(pipeB.mv));
      checkOutput("period_out", 32'(period_out), 32'(pipeB.period));
      checkOutput("high_out",   32'(high_out),   32'(pipeB.high));
      checkOutput("in_range",   32'(in_range),   32'(pipeB.inr));
      checkOutput("locked",     32'(locked),     32'(pipeB.lck));
      checkOutput("timeout",    32'(timeout),    32'(pipeB.to));
      pipeB = pipeA;
      pipeA = cur;
      @(negedge clock_in);
   endtask

   // One sig_in period: hi cycles high, then lo cycles low.
   task automatic applyStimulus(input int hi, input int lo);
      repeat (hi) stepCycle(1'b1);
      repeat (lo) stepCycle(1'b0);
   endtask

   // Holds reset for n cycles while sig_in keeps its current level.
   task automatic resetPulse(input int n);
      reset = 1'b1;
      repeat (n) stepCycle(sig_in);
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      sig_in = 1'b0;
      modelStep(1'b0, 1'b1);
      @(negedge clock_in);
      resetPulse(2);
      checkOutput("reset_period", 32'(period_out), 32'd0);
      checkOutput("reset_locked", 32'(locked), 32'd0);
      repeat (3) stepCycle(1'b0);

      // Nominal 10-cycle clock with 5 cycles high.
      repeat (8) applyStimulus(5, 5);
      checkOutput("train_period", 32'(period_out), 32'd10);
`ifdef CLOCK_RATIO_METER_DUTY_EN
      checkOutput("train_high", 32'(high_out), 32'd5);
`else
      checkOutput("train_high", 32'(high_out), 32'd0);
`endif
      checkOutput("train_locked", 32'(locked), 32'd1);

      // One long period breaks lock, then it recovers.
      applyStimulus(7, 7);
      repeat (5) applyStimulus(5, 5);
      checkOutput("relock", 32'(locked), 32'd1);

      // Timeout, then recovery.
      applyStimulus(5, 40);
      checkOutput("timeout_set", 32'(timeout), 32'd1);
      checkOutput("timeout_unlock", 32'(locked), 32'd0);
      repeat (3) applyStimulus(5, 5);
      checkOutput("timeout_clear", 32'(timeout), 32'd0);

      // Tolerance and timeout-limit boundaries.
      applyStimulus(4, 5);
      applyStimulus(5, 6);
      applyStimulus(4, 4);
      applyStimulus(6, 6);
      applyStimulus(5, 20);
      applyStimulus(5, 21);
      repeat (3) applyStimulus(5, 5);

      // Reset in the middle of a high phase.
      applyStimulus(3, 0);
      resetPulse(1);
      applyStimulus(2, 5);
      repeat (5) applyStimulus(5, 5);

      // Randomised periods, with occasional long gaps and resets.
      for (int i = 0; i < 150; i++) begin
         int hi, lo;
         hi = $urandom_range(1, 8);
         lo = $urandom_range(1, 8);
         if ($urandom_range(0, 2) == 0) lo = 10 - hi + $urandom_range(0, 2) - 1;
         if (lo < 1) lo = 1;
         if ($urandom_range(0, 9) == 0) lo = $urandom_range(15, 30);
         applyStimulus(hi, lo);
         if ($urandom_range(0, 39) == 0) resetPulse(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
